mips_mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the MIPS core. A single shared memory port serves both instruction fetch and data access, and this block arbitrates that port. It consumes the mips_decode outputs and steps each instruction through FETCH / DECODE / EXEC / MEM / WB. It drives the variable-latency memory handshake, produces architectural write strobes (PC, IR, MDR, register file), counts retired instructions, and halts on decode exceptions or memory timeouts.

---
 rtl/mips_ctrl_pkg.sv | 26 ++
 rtl/mem_wait_timer.sv | 24 ++
 rtl/mips_mc_sequencer.sv | 138 +++++++++++++
 tb/tb_mips_mc_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle control sequencer.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic ADDR_PC   = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

  localparam int TIMEOUT_DEF = 16;

  // Memory-port request fields; all derived from state only.
  typedef struct packed {
    logic req;
    logic addr_sel;
    logic wr;
  } mem_ctl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled request cycles; expired flags the last cycle before a bus error.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && cnt != LAST) cnt <= cnt + 8'd1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer arbitrating one shared memory port.
module mips_mc_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             except,
  input  logic             writeenable,
  input  logic             mem_read,
  input  logic             word_we,
  input  logic             byte_we,
  input  logic             addm,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic             mem_wr,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic             retire,
  output logic [CNT_W-1:0] inst_count,
  output logic             halted,
  output logic             bus_err
);

  state_t   state, state_nx;
  mem_ctl_t mctl;
  logic     we_q, store_q;
  logic     tmr_exp, timeout_hit;

  // Decode inputs are only valid during DECODE, so keep what later states need.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      store_q <= 1'b0;
    end else if (state == S_DECODE) begin
      we_q    <= writeenable;
      store_q <= word_we | byte_we;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    mctl.req      = (state == S_FETCH) || (state == S_MEM);
    mctl.addr_sel = (state == S_MEM) ? ADDR_DATA : ADDR_PC;
    mctl.wr       = (state == S_MEM) && store_q;
  end

  assign mem_req      = mctl.req;
  assign mem_addr_sel = mctl.addr_sel;
  assign mem_wr       = mctl.wr;
  assign timeout_hit  = mctl.req && !mem_ready && tmr_exp;

  always_comb begin
    state_nx = state;
    ir_we    = 1'b0;
    mdr_we   = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    retire   = 1'b0;
    case (state)
      S_IDLE:  state_nx = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          ir_we    = 1'b1;
          state_nx = S_DECODE;
        end else if (tmr_exp) begin
          state_nx = S_HALT;
        end
      end
      S_DECODE: begin
        if (except)                                   state_nx = S_HALT;
        else if (mem_read || addm || word_we || byte_we) state_nx = S_MEM;
        else                                          state_nx = S_EXEC;
      end
      S_EXEC: begin
        reg_we   = we_q;
        pc_we    = 1'b1;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (store_q) begin
            pc_we    = 1'b1;
            retire   = 1'b1;
            state_nx = S_FETCH;
          end else begin
            mdr_we   = 1'b1;
            state_nx = S_WB;
          end
        end else if (tmr_exp) begin
          state_nx = S_HALT;
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        pc_we    = 1'b1;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (state_nx != state),
    .en      (mctl.req && !mem_ready),
    .expired (tmr_exp)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted  <= 1'b0;
      bus_err <= 1'b0;
    end else if (state != S_HALT && state_nx == S_HALT) begin
      halted  <= 1'b1;
      bus_err <= timeout_hit;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      inst_count <= '0;
    else if (retire) inst_count <= inst_count + 1'b1;
  end

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Scoreboard bench: stimulus queues expected per-instruction events, a monitor checks them.
module tb_mips_mc_sequencer;

  localparam logic [5:0] I_ADD  = 6'b010000; // {except,we,mem_read,word_we,byte_we,addm}
  localparam logic [5:0] I_BR   = 6'b000000;
  localparam logic [5:0] I_LW   = 6'b011000;
  localparam logic [5:0] I_ADDM = 6'b010001;
  localparam logic [5:0] I_SW   = 6'b000100;
  localparam logic [5:0] I_SB   = 6'b000010;
  localparam logic [5:0] I_EXC  = 6'b100000;

  typedef struct {
    int lat, req, dat, wr, ir, mdr, rg, pc, cnt, hlt, berr;
  } exp_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic except = 1'b0, writeenable = 1'b0, mem_read = 1'b0;
  logic word_we = 1'b0, byte_we = 1'b0, addm = 1'b0;
  logic rdy_resp = 1'b0, rdy_force = 1'b0;
  logic mem_ready;
  logic mem_req, mem_addr_sel, mem_wr, ir_we, mdr_we, reg_we, pc_we, retire;
  logic halted, bus_err;
  logic [31:0] inst_count;
  logic w_req, w_sel, w_wr, w_ir, w_mdr, w_reg, w_pc, w_ret, w_halt, w_berr;
  logic [1:0] cnt_w;

  int   n_cmp = 0, n_bad = 0;
  exp_t exp_q[$];
  int   lat_q[$];
  logic [5:0] prog_q[$];

  assign mem_ready = rdy_resp | rdy_force;
  always #5 clock = ~clock;

  mips_mc_sequencer #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clock(clock), .reset(rst_n), .except(except), .writeenable(writeenable),
    .mem_read(mem_read), .word_we(word_we), .byte_we(byte_we), .addm(addm),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_addr_sel(mem_addr_sel),
    .mem_wr(mem_wr), .ir_we(ir_we), .mdr_we(mdr_we), .reg_we(reg_we),
    .pc_we(pc_we), .retire(retire), .inst_count(inst_count),
    .halted(halted), .bus_err(bus_err)
  );

  // Narrow-counter twin in lockstep, used to observe counter wrap.
  mips_mc_sequencer #(.TIMEOUT(4), .CNT_W(2)) dut_w (
    .clock(clock), .reset(rst_n), .except(except), .writeenable(writeenable),
    .mem_read(mem_read), .word_we(word_we), .byte_we(byte_we), .addm(addm),
    .mem_ready(mem_ready), .mem_req(w_req), .mem_addr_sel(w_sel),
    .mem_wr(w_wr), .ir_we(w_ir), .mdr_we(w_mdr), .reg_we(w_reg),
    .pc_we(w_pc), .retire(w_ret), .inst_count(cnt_w),
    .halted(w_halt), .bus_err(w_berr)
  );

  task automatic cmp(input string nm, input longint act, input longint exv);
    n_cmp++;
    if (act != exv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exv, $time);
    end
  endtask

  function automatic void ex(int lat, int req, int dat, int wr, int ir, int mdr,
                             int rg, int pc, int cnt, int hlt, int berr);
    exp_t e;
    e.lat = lat; e.req = req; e.dat = dat; e.wr = wr; e.ir = ir; e.mdr = mdr;
    e.rg = rg; e.pc = pc; e.cnt = cnt; e.hlt = hlt; e.berr = berr;
    exp_q.push_back(e);
  endfunction

  // Memory responder: each request takes the next latency from lat_q (0 = never).
  int k = 0, cur_lat = 1;
  always @(posedge clock) begin
    #1;
    if (!rst_n || !mem_req) begin
      rdy_resp = 1'b0;
      k = 0;
    end else begin
      if (k == 0) cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
      k++;
      rdy_resp = (cur_lat != 0 && k == cur_lat);
      if (rdy_resp) k = 0;
    end
  end

  // Decoder stand-in: presents the next program word after each IR load.
  bit ld = 1'b0;
  always @(negedge clock) if (rst_n && ir_we) ld = 1'b1;
  always @(posedge clock) begin
    logic [5:0] iw;
    #1;
    if (ld) begin
      ld = 1'b0;
      iw = (prog_q.size() != 0) ? prog_q.pop_front() : I_ADD;
      {except, writeenable, mem_read, word_we, byte_we, addm} = iw;
    end
  end

  // Monitor: accumulate strobes per instruction window, check on retire or halt entry.
  int a_lat, a_req, a_dat, a_wr, a_ir, a_mdr, a_rg, a_pc;
  bit halt_seen = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      {a_lat, a_req, a_dat, a_wr, a_ir, a_mdr, a_rg, a_pc} = '0;
      halt_seen = 1'b0;
    end else begin
      a_lat++;
      a_req += int'(mem_req);  a_dat += int'(mem_addr_sel); a_wr += int'(mem_wr);
      a_ir  += int'(ir_we);    a_mdr += int'(mdr_we);       a_rg += int'(reg_we);
      a_pc  += int'(pc_we);
      if (retire || (halted && !halt_seen)) begin
        if (halted) halt_seen = 1'b1;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_event: got retire=%0d halted=%0d expected none", retire, halted);
        end else begin
          e = exp_q.pop_front();
          cmp("latency", a_lat, e.lat);   cmp("mem_req_cycles", a_req, e.req);
          cmp("addr_data_cycles", a_dat, e.dat); cmp("mem_wr_cycles", a_wr, e.wr);
          cmp("ir_we_cycles", a_ir, e.ir); cmp("mdr_we_cycles", a_mdr, e.mdr);
          cmp("reg_we_cycles", a_rg, e.rg); cmp("pc_we_cycles", a_pc, e.pc);
          cmp("inst_count", inst_count, e.cnt);
          cmp("inst_count_w2", cnt_w, e.cnt % 4);
          cmp("halted", halted, e.hlt);   cmp("bus_err", bus_err, e.berr);
        end
        {a_lat, a_req, a_dat, a_wr, a_ir, a_mdr, a_rg, a_pc} = '0;
      end
    end
  end

  task automatic start();
    rst_n = 1'b0;
    exp_q.delete(); lat_q.delete(); prog_q.delete();
    repeat (2) @(negedge clock);
  endtask

  task automatic release_rst();
    @(posedge clock);
    #2 rst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got %0d pending events expected 0", nm, exp_q.size());
    end
    #2;
  endtask

  initial begin
    // Reset state
    start();
    cmp("rst_mem_req", mem_req, 0);   cmp("rst_ir_we", ir_we, 0);
    cmp("rst_pc_we", pc_we, 0);       cmp("rst_retire", retire, 0);
    cmp("rst_inst_count", inst_count, 0);
    cmp("rst_halted", halted, 0);     cmp("rst_bus_err", bus_err, 0);

    // ALU stream with zero-wait memory, plus a branch; twin counter wraps at 4
    prog_q = '{I_ADD, I_ADD, I_ADD, I_ADD, I_ADD, I_BR};
    ex(4, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 1; i < 5; i++) ex(3, 1, 0, 0, 1, 0, 1, 1, i, 0, 0);
    ex(3, 1, 0, 0, 1, 0, 0, 1, 5, 0, 0);
    release_rst();
    drain("alu");

    // lw with 2-cycle fetch / 3-cycle data, then addm, sw, sb (2-cycle data)
    start();
    prog_q = '{I_LW, I_ADDM, I_SW, I_SB};
    lat_q  = '{2, 3, 1, 1, 1, 1, 1, 2};
    ex(8, 5, 3, 0, 1, 1, 1, 1, 0, 0, 0);
    ex(4, 2, 1, 0, 1, 1, 1, 1, 1, 0, 0);
    ex(3, 2, 1, 1, 1, 0, 0, 1, 2, 0, 0);
    ex(4, 3, 2, 2, 1, 0, 0, 1, 3, 0, 0);
    release_rst();
    drain("mem");

    // Decode exception halts; later mem_ready pulses must be ignored
    start();
    prog_q = '{I_ADD, I_EXC};
    ex(4, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    ex(3, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    release_rst();
    drain("except");
    repeat (3) begin
      @(posedge clock); #1 rdy_force = 1'b1;
      @(posedge clock); #1 rdy_force = 1'b0;
    end
    repeat (3) @(negedge clock);
    cmp("exc_halted", halted, 1);     cmp("exc_bus_err", bus_err, 0);
    cmp("exc_mem_req", mem_req, 0);   cmp("exc_inst_count", inst_count, 1);

    // Fetch never answered: bus error after 4 request cycles
    start();
    lat_q = '{0};
    ex(6, 4, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    release_rst();
    drain("timeout");

    // Ready on the last allowed cycle wins
    start();
    prog_q = '{I_ADD, I_ADD};
    lat_q  = '{4};
    ex(7, 4, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    ex(3, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0);
    release_rst();
    drain("late_ready");

    // Reset during an outstanding data request
    start();
    prog_q = '{I_ADD, I_LW};
    lat_q  = '{1, 1, 0};
    ex(4, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    release_rst();
    begin
      int c = 0;
      while (!(mem_req && mem_addr_sel) && c < 50) begin
        @(negedge clock); c++;
      end
      cmp("reach_mem_state", int'(mem_req && mem_addr_sel), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    cmp("async_mem_req", mem_req, 0); cmp("async_addr_sel", mem_addr_sel, 0);
    cmp("async_inst_count", inst_count, 0);
    cmp("async_reg_we", reg_we, 0);   cmp("async_mdr_we", mdr_we, 0);
    start();
    prog_q = '{I_ADD};
    ex(4, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    release_rst();
    drain("after_reset");

    rst_n = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
